// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared constants and types for the SID pot converter
package sid_pkg;
    localparam int POT_PHASE_BITS = 9;
    localparam int POT_VAL_BITS   = 8;
    localparam logic [POT_VAL_BITS-1:0] POT_MAX = 8'hFF;

    typedef logic [POT_VAL_BITS-1:0] pot_val_t;

    function automatic pot_val_t pot_sat_inc(input pot_val_t v);
        return (v == POT_MAX) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/sid_pot_sync.sv
// rtl/sid_pot_sync.sv - single-bit multi-stage comparator synchronizer
module sid_pot_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/sid_pot_adc.sv
// rtl/sid_pot_adc.sv - POTX/POTY integrating RC converter with shared 512-tick sequencer
module sid_pot_adc
    import sid_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              phi2_en,
    input  logic [NCH-1:0]                    pot_cmp,
    output logic                              pot_discharge,
    output logic [NCH-1:0][POT_VAL_BITS-1:0]  pot_val,
    output logic                              pot_valid
);
    logic [POT_PHASE_BITS-1:0]         phase;
    logic [POT_PHASE_BITS-1:0]         phase_nxt;
    logic [NCH-1:0]                    sync;
    logic [NCH-1:0]                    lock;
    logic [NCH-1:0]                    lock_nxt;
    logic [NCH-1:0][POT_VAL_BITS-1:0]  cnt;
    logic [NCH-1:0][POT_VAL_BITS-1:0]  cnt_nxt;
    logic                              measure;
    logic                              end_conv;

    for (genvar g = 0; g < NCH; g++) begin : g_sync
        sid_pot_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (pot_cmp[g]),
            .q   (sync[g])
        );
    end

    assign phase_nxt = phase + 9'd1;
    assign measure   = phase[POT_PHASE_BITS-1];
    assign end_conv  = (phase == 9'h1FF);

    // Count holds on the tick the comparator is first seen high, so cnt equals that tick.
    always_comb begin
        cnt_nxt  = cnt;
        lock_nxt = lock;
        for (int i = 0; i < NCH; i++) begin
            if (!lock[i]) begin
                if (sync[i]) begin
                    lock_nxt[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = pot_sat_inc(cnt[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase         <= '0;
            cnt           <= '0;
            lock          <= '0;
            pot_discharge <= 1'b1;
            pot_val       <= '0;
            pot_valid     <= 1'b0;
        end else begin
            pot_valid <= 1'b0;
            if (phi2_en) begin
                phase         <= phase_nxt;
                pot_discharge <= ~phase_nxt[POT_PHASE_BITS-1];
                if (measure) begin
                    if (end_conv) begin
                        // tick-255 sample is folded into the published result
                        pot_val   <= cnt_nxt;
                        pot_valid <= 1'b1;
                        cnt       <= '0;
                        lock      <= '0;
                    end else begin
                        cnt  <= cnt_nxt;
                        lock <= lock_nxt;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sid_pot_adc.sv
// tb/tb_sid_pot_adc.sv - scoreboard bench for sid_pot_adc
module tb_sid_pot_adc;
    logic            clk = 1'b0;
    logic            rst;
    logic            phi2_en;
    logic [1:0]      pot_cmp;
    logic            pot_discharge;
    logic [1:0][7:0] pot_val;
    logic            pot_valid;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    int          phi_cnt;
    logic        disch_at_drive;
    int          lock_tick[2];
    logic        disch_val;
    bit          rnd_after;

    sid_pot_adc #(.NCH(2), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .phi2_en       (phi2_en),
        .pot_cmp       (pot_cmp),
        .pot_discharge (pot_discharge),
        .pot_val       (pot_val),
        .pot_valid     (pot_valid)
    );

    always #5 clk = ~clk;

    // Desired synchronized comparator level for channel ch at phase p.
    function automatic logic want(input int ch, input int p);
        int k;
        if (p < 256) return disch_val;
        k = p - 256;
        if (k < lock_tick[ch]) return 1'b0;
        if (k == lock_tick[ch]) return 1'b1;
        if (rnd_after) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    function automatic logic [1:0] wv(input int p);
        return {want(1, p), want(0, p)};
    endfunction

    function automatic logic [7:0] exp_val(input int lt);
        return (lt > 255) ? 8'hFF : 8'(lt);
    endfunction

    task automatic observe();
        logic [15:0] expv;
        if (pot_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed pot_val=%h expected no pulse", pot_val);
            end
            if (sb.size() != 0) begin
                expv = sb.pop_front();
                checks++;
                assert (pot_val === expv) else begin
                    errors++;
                    $error("FAIL pot_val observed %h expected %h", pot_val, expv);
                end
            end
            checks++;
            assert (phi_cnt === 512) else begin
                errors++;
                $error("FAIL valid_spacing observed %0d expected 512", phi_cnt);
            end
            phi_cnt = 0;
        end
    endtask

    task automatic clk_step(input logic phi, input logic [1:0] cmp);
        @(negedge clk);
        observe();
        disch_at_drive = pot_discharge;
        phi2_en = phi;
        pot_cmp = cmp;
        if (phi) phi_cnt++;
    endtask

    // Drive phases [first, last) of a conversion with gap clks per phi2_en.
    task automatic run_conv(input int gap, input int first, input int last);
        int hi  = 0;
        int bad = 0;
        if (first == 0)
            sb.push_back({exp_val(lock_tick[1]), exp_val(lock_tick[0])});
        for (int t = first; t < last; t++) begin
            if (gap == 1) begin
                clk_step(1'b1, wv((t + 2) % 512));
            end else begin
                clk_step(1'b1, pot_cmp);
            end
            hi += int'(disch_at_drive);
            if (disch_at_drive !== (t < 256)) bad++;
            for (int j = 1; j < gap; j++) clk_step(1'b0, wv((t + 1) % 512));
        end
        if (last == 512) begin
            clk_step(1'b0, pot_cmp);
            checks++;
            assert (sb.size() === 0) else begin
                errors++;
                $error("FAIL valid_missing observed %0d pending expected 0", sb.size());
            end
            if (first == 0) begin
                checks++;
                assert (hi === 256 && bad === 0) else begin
                    errors++;
                    $error("FAIL discharge_span observed hi=%0d bad=%0d expected hi=256 bad=0", hi, bad);
                end
            end
        end
    endtask

    task automatic set_test(input int l0, input int l1, input logic dv, input bit rnd);
        lock_tick[0] = l0;
        lock_tick[1] = l1;
        disch_val    = dv;
        rnd_after    = rnd;
    endtask

    initial begin
        rst = 1'b1;
        phi2_en = 1'b0;
        pot_cmp = 2'b00;
        phi_cnt = 0;
        set_test(999, 999, 1'b0, 1'b0);
        #12;
        checks++;
        assert (pot_val === 16'h0000) else begin
            errors++; $error("FAIL reset_pot_val observed %h expected 0000", pot_val);
        end
        checks++;
        assert (pot_discharge === 1'b1) else begin
            errors++; $error("FAIL reset_discharge observed %b expected 1", pot_discharge);
        end
        checks++;
        assert (pot_valid === 1'b0) else begin
            errors++; $error("FAIL reset_valid observed %b expected 0", pot_valid);
        end
        @(negedge clk);
        rst = 1'b0;

        // conversion producing 0x80, then reset partway into MEASURE
        set_test(128, 999, 1'b0, 1'b0);
        run_conv(3, 0, 512);
        set_test(20, 30, 1'b0, 1'b0);
        sb.push_back(16'h0);
        run_conv(3, 1, 300);
        void'(sb.pop_back());
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        assert (pot_val === 16'h0000) else begin
            errors++; $error("FAIL midreset_pot_val observed %h expected 0000", pot_val);
        end
        checks++;
        assert (pot_discharge === 1'b1) else begin
            errors++; $error("FAIL midreset_discharge observed %b expected 1", pot_discharge);
        end
        checks++;
        assert (pot_valid === 1'b0) else begin
            errors++; $error("FAIL midreset_valid observed %b expected 0", pot_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        phi2_en = 1'b0;
        pot_cmp = 2'b00;
        phi_cnt = 0;

        set_test(45, 999, 1'b0, 1'b0);
        run_conv(3, 0, 511);
        checks++;
        assert (pot_val === 16'h0000) else begin
            errors++; $error("FAIL post_reset_hold observed %h expected 0000", pot_val);
        end
        run_conv(3, 511, 512);

        set_test(100, 999, 1'b0, 1'b0);
        run_conv(3, 0, 512);

        set_test(0, 0, 1'b1, 1'b0);
        run_conv(3, 0, 512);

        set_test(10, 50, 1'b0, 1'b1);
        run_conv(4, 0, 512);

        set_test(255, 254, 1'b0, 1'b0);
        run_conv(3, 0, 512);

        set_test(254, 255, 1'b0, 1'b0);
        run_conv(1, 0, 512);

        set_test(37, 200, 1'b0, 1'b0);
        run_conv(1, 0, 512);
        run_conv(8, 0, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
